// File: rtl/vscpu_mmio_pkg.sv
// Shared definitions for VerySimpleCPU memory-mapped peripherals:
// register offsets, CTRL/STAT bit positions and divider FSM states.
package vscpu_mmio_pkg;

    localparam logic [13:0] DEF_BASE_ADDR = 14'h3FF0;

    localparam logic [2:0] OFF_DIVIDEND  = 3'd0;
    localparam logic [2:0] OFF_DIVISOR   = 3'd1;
    localparam logic [2:0] OFF_CTRL      = 3'd2;
    localparam logic [2:0] OFF_QUOTIENT  = 3'd3;
    localparam logic [2:0] OFF_REMAINDER = 3'd4;

    localparam int unsigned BIT_START    = 0;
    localparam int unsigned BIT_IRQ_EN   = 1;
    localparam int unsigned BIT_DONE_CLR = 2;
    localparam int unsigned BIT_BUSY     = 0;
    localparam int unsigned BIT_DONE     = 2;
    localparam int unsigned BIT_DZ       = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

endpackage

// File: rtl/div_core.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Divide-by-zero completes immediately with q=all-ones, r=dividend.
module div_core
    import vscpu_mmio_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_t           state, state_next;
    logic [WIDTH:0]   rem, dvs, rem_sh, rem_step;
    logic [WIDTH-1:0] dq, dq_step;
    logic [CW-1:0]    cnt;
    logic             ge;

    always_comb begin
        rem_sh   = (rem << 1) | {{WIDTH{1'b0}}, dq[WIDTH-1]};
        ge       = (rem_sh >= dvs);
        rem_step = ge ? (rem_sh - dvs) : rem_sh;
        dq_step  = {dq[WIDTH-2:0], ge};
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = (divisor == '0) ? S_DONE : S_CALC;
            S_CALC: if (cnt == '0) state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            rem   <= '0;
            dvs   <= '0;
            dq    <= '0;
            cnt   <= '0;
            dz    <= 1'b0;
            q     <= '0;
            r     <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && start) begin
                dvs <= {1'b0, divisor};
                dq  <= dividend;
                rem <= '0;
                cnt <= CW'(WIDTH - 1);
                dz  <= (divisor == '0);
                if (divisor == '0) begin
                    q <= '1;
                    r <= dividend;
                end
            end else if (state == S_CALC) begin
                rem <= rem_step;
                dq  <= dq_step;
                cnt <= cnt - CW'(1);
                if (cnt == '0) begin
                    q <= dq_step;
                    r <= rem_step[WIDTH-1:0];
                end
            end
        end
    end

    assign busy = (state == S_CALC);
    assign done = (state == S_DONE);

endmodule

// File: rtl/mmio_floor_divider.sv
// Memory-mapped floor-division peripheral on the VerySimpleCPU RAM bus:
// bus decode, register file, registered read data and level interrupt.
module mmio_floor_divider
    import vscpu_mmio_pkg::*;
#(
    parameter logic [13:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int unsigned WIDTH     = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_we,
    input  logic [13:0] i_addr,
    input  logic [31:0] i_data_in,
    output logic [31:0] o_data_out,
    output logic        o_sel,
    output logic        o_interrupt
);

    logic [WIDTH-1:0] dividend, divisor, q, r;
    logic             busy, done_pulse, dz;
    logic             done_bit, irq_en;
    logic             done_next, irq_en_next;
    logic             hit, ctrl_wr, start_ok;
    logic [2:0]       off;
    logic [31:0]      rd_data;

    assign hit      = (i_addr[13:3] == BASE_ADDR[13:3]);
    assign off      = i_addr[2:0];
    assign ctrl_wr  = i_we && hit && (off == OFF_CTRL);
    // Only an idle core accepts START; the done-pulse cycle is not idle.
    assign start_ok = ctrl_wr && i_data_in[BIT_START] && !busy && !done_pulse;

    always_comb begin
        done_next   = done_bit;
        irq_en_next = irq_en;
        if (ctrl_wr) irq_en_next = i_data_in[BIT_IRQ_EN];
        if (done_pulse)
            done_next = 1'b1;
        else if (start_ok || (ctrl_wr && i_data_in[BIT_DONE_CLR]))
            done_next = 1'b0;
    end

    always_comb begin
        rd_data = '0;
        case (off)
            OFF_DIVIDEND:  rd_data = 32'(dividend);
            OFF_DIVISOR:   rd_data = 32'(divisor);
            OFF_CTRL: begin
                rd_data[BIT_BUSY]   = busy;
                rd_data[BIT_IRQ_EN] = irq_en;
                rd_data[BIT_DONE]   = done_bit;
                rd_data[BIT_DZ]     = dz;
            end
            OFF_QUOTIENT:  rd_data = 32'(q);
            OFF_REMAINDER: rd_data = 32'(r);
            default:       rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dividend    <= '0;
            divisor     <= '0;
            done_bit    <= 1'b0;
            irq_en      <= 1'b0;
            o_interrupt <= 1'b0;
            o_sel       <= 1'b0;
            o_data_out  <= '0;
        end else begin
            if (i_we && hit && off == OFF_DIVIDEND) dividend <= i_data_in[WIDTH-1:0];
            if (i_we && hit && off == OFF_DIVISOR)  divisor  <= i_data_in[WIDTH-1:0];
            done_bit    <= done_next;
            irq_en      <= irq_en_next;
            o_interrupt <= done_next && irq_en_next;
            o_sel       <= hit;
            o_data_out  <= hit ? rd_data : '0;
        end
    end

    div_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst_n    (rst),
        .start    (start_ok),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done_pulse),
        .dz       (dz),
        .q        (q),
        .r        (r)
    );

endmodule
